// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bundle: ID operand/destination info, branch and memory
// status in; pipeline enables, flushes, forward selects and stats out.
interface pipe_hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              cpu_en;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [ADDR_W-1:0] id_wr_addr;
  logic              id_is_load;
  logic              id_mem_req;
  logic              ex_branch_taken;
  logic              MIO_ready;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              mem_wait;
  logic              timeout_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  wait_cnt;

  modport master (
    output cpu_en, id_valid, id_rs_addr, id_rt_addr,
    output id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
    output id_is_load, id_mem_req, ex_branch_taken, MIO_ready,
    input  pc_en, ifid_en, ifid_flush, idex_flush,
    input  fwd_a_sel, fwd_b_sel, mem_wait, timeout_err,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  cpu_en, id_valid, id_rs_addr, id_rt_addr,
    input  id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
    input  id_is_load, id_mem_req, ex_branch_taken, MIO_ready,
    output pc_en, ifid_en, ifid_flush, idex_flush,
    output fwd_a_sel, fwd_b_sel, mem_wait, timeout_err,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit for a 5-stage pipe.
// Tracks EX/MEM/WB destinations, stalls, flushes and watches memory waits.
module pipe_hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int FORWARDING  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WD_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              ld;
    logic              mreq;
  } rec_t;

  rec_t ex_q, mem_q, wb_q;
  rec_t ex_d, mem_d, wb_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic raw_wait, fire, mw, adv;
  logic stall, flush;
  logic ha_ex, hb_ex, ha_mem, hb_mem;
  logic unused_rec;

  assign unused_rec = ^{wb_q.ld, wb_q.mreq, mem_q.ld};

  function automatic logic hit(rec_t s,
                               logic [ADDR_W-1:0] r,
                               logic u);
    return s.v & s.wr & (s.addr == r) & (r != '0) & u;
  endfunction

  // A load still in EX has no result yet: select nothing rather than
  // fall through to an older, stale stage.
  function automatic logic [1:0] fsel(rec_t e, rec_t m,
                                      rec_t w,
                                      logic [ADDR_W-1:0] r,
                                      logic u);
    if (hit(e, r, u)) return e.ld ? 2'd0 : 2'd1;
    if (hit(m, r, u)) return 2'd2;
    if (hit(w, r, u)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat(
    logic [CNT_W-1:0] c, logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    raw_wait = mem_q.v & mem_q.mreq & ~hz.MIO_ready;
    fire     = (MEM_TIMEOUT != 0) && raw_wait &&
               (wd_q == WD_W'(MEM_TIMEOUT));
    mw       = raw_wait & ~fire;
    adv      = hz.cpu_en & ~mw;
    flush    = ex_q.v & hz.ex_branch_taken;

    ha_ex  = hit(ex_q, hz.id_rs_addr, hz.id_uses_rs);
    hb_ex  = hit(ex_q, hz.id_rt_addr, hz.id_uses_rt);
    ha_mem = hit(mem_q, hz.id_rs_addr, hz.id_uses_rs);
    hb_mem = hit(mem_q, hz.id_rt_addr, hz.id_uses_rt);
    if (FORWARDING != 0)
      stall = (ha_ex | hb_ex) & ex_q.ld;
    else
      stall = ha_ex | hb_ex | ha_mem | hb_mem;

    hz.pc_en      = 1'b0;
    hz.ifid_en    = 1'b0;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    unique case (1'b1)
      !adv: ;
      adv && flush: begin
        hz.pc_en      = 1'b1;
        hz.ifid_en    = 1'b1;
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
      end
      adv && !flush && stall:
        hz.idex_flush = 1'b1;
      adv && !flush && !stall: begin
        hz.pc_en   = 1'b1;
        hz.ifid_en = 1'b1;
      end
    endcase

    hz.fwd_a_sel = 2'd0;
    hz.fwd_b_sel = 2'd0;
    if (FORWARDING != 0) begin
      hz.fwd_a_sel = fsel(ex_q, mem_q, wb_q,
                          hz.id_rs_addr, hz.id_uses_rs);
      hz.fwd_b_sel = fsel(ex_q, mem_q, wb_q,
                          hz.id_rt_addr, hz.id_uses_rt);
    end
    hz.mem_wait = mw;

    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (adv) begin
      wb_d     = mem_q;
      mem_d    = ex_q;
      ex_d.v    = hz.id_valid & ~hz.idex_flush;
      ex_d.wr   = hz.id_wr_en;
      ex_d.addr = hz.id_wr_addr;
      ex_d.ld   = hz.id_is_load;
      ex_d.mreq = hz.id_mem_req;
    end

    wd_d = '0;
    if (mw)
      wd_d = (wd_q == WD_W'(MEM_TIMEOUT)) ?
             wd_q : wd_q + WD_W'(1);
    terr_d  = terr_q | fire;
    stall_d = sat(stall_q, adv & ~flush & stall);
    flush_d = sat(flush_q, adv & flush);
    wait_d  = sat(wait_q, hz.cpu_en & mw);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  assign hz.timeout_err = terr_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
  assign hz.wait_cnt    = wait_q;
endmodule
